rc_car_top: RTL and testbench
=============================

// Module: rc_car_top
// PURPOSE
//  RC-car control top: debounced buttons set motor speed level and steering position;
//  gear switch caps the DC-motor duty. Drives DC-motor PWM (20 kHz), servo PWM (50 Hz),
//  a 4-digit multiplexed 7-seg display and 8 status LEDs. Sits directly on board pins.
// PARAMETERS
//  DEBOUNCE_CYCLES  50_000     stable-sample cycles before a button edge is accepted (0.5 ms)
//  DC_PERIOD        5_000      DC PWM period in clocks (20 kHz @ 100 MHz)
//  SERVO_PERIOD     2_000_000  servo frame in clocks (20 ms)
//  SERVO_CENTER     150_000    servo pulse at position 0 (1.5 ms)
//  SERVO_STEP       12_500     pulse change per position step (0.125 ms)
//  SCAN_CYCLES      100_000    clocks each display digit is active (1 ms)
// PORTS
//  clk_100mhz       in   1  system clock, 100 MHz; all logic on rising edge
//  rst_btn          in   1  synchronous, active-low reset
//  btn_accel        in   1  raise speed level (async, bouncy, active-high)
//  btn_decel        in   1  lower speed level
//  btn_servo_left   in   1  steer one step left
//  btn_servo_right  in   1  steer one step right
//  gear_sw          in   3  gear select; 0 = neutral, 1..5 valid, 6/7 treated as 5
//  dc_pwm           out  1  DC motor PWM, active-high
//  servo_pwm        out  1  servo PWM, active-high
//  fnd_sel          out  4  digit select, active-low one-hot, bit0 = rightmost
//  fnd_seg          out  8  segments active-low {dp,g,f,e,d,c,b,a}
//  leds             out  8  status: [7:4] speed level, [3:0] servo position (2's complement)
// BEHAVIOUR
//  Reset (rst_btn=0 at clk edge): speed=0, pos=0, all counters 0, dc_pwm=0, servo_pwm=0,
//   fnd_sel=4'b1110, fnd_seg=8'hC0 ('0'), leds=8'h00.
//  Buttons: 2-FF synchronizer, then counter; level accepted after DEBOUNCE_CYCLES equal
//   samples; one-cycle pulse on accepted 0->1 transition only. Holding gives one step.
//  Speed level 0..10: accel pulse +1, decel pulse -1, saturating both ends.
//   accel and decel pulses in same cycle -> no change.
//  Servo position -4..+4: right +1, left -1, saturating; simultaneous -> no change.
//  Gear g = (gear_sw>5) ? 5 : gear_sw. Duty% = min(speed*10, g*20); g=0 -> 0%.
//  DC PWM: counter 0..DC_PERIOD-1, wraps. Threshold = duty% * (DC_PERIOD/100), latched
//   when counter==0; dc_pwm = (counter < threshold). 0% -> constant 0, 100% -> constant 1.
//   Gear/speed changes mid-period take effect at next period start (glitch-free).
//  Servo PWM: counter 0..SERVO_PERIOD-1; width = SERVO_CENTER + pos*SERVO_STEP
//   (signed, 100_000..200_000) latched at counter==0; servo_pwm = (counter < width).
//  Display: scan counter advances digit every SCAN_CYCLES, order 0->1->2->3->0.
//   digit3 = gear g with dp lit; digit2 = duty hundreds (blank unless 100);
//   digit1 = duty tens (blank if duty<10); digit0 = duty units (always shown).
//   Blank = 8'hFF. Codes '0'..'9' = C0,F9,A4,B0,99,92,82,F8,80,90.
//  leds[7:4] = speed level binary; leds[3:0] = pos[3:0]; registered, update 1 clk after change.
//  Reset mid-operation: all state returns to reset values on the next edge; no residual pulses.
// TESTING
//  1. Reset held, release: dc_pwm=0, servo pulse 150_000 clocks every 2_000_000, leds=00.
//  2. gear 1, 5 accel presses (1 ms each, 1 ms gap) -> speed 5, leds[7:4]=5, duty 20%:
//     dc_pwm high 1_000 of 5_000 clocks; display "1.  20".
//  3. Switch gear to 3 -> duty 50% (2_500 high) from next period; display "3.  50".
//  4. 3 decel presses -> speed 2, duty 20%; 12 accel -> saturate speed 10, gear 5 -> 100% const high.
//  5. 2 right presses -> pos +2, servo pulse 175_000; then 2 left -> pos 0, 150_000;
//     6 left -> saturate -4, 100_000, leds[3:0]=4'hC.
//  6. Bounce 10 us glitches shorter than DEBOUNCE_CYCLES -> no step; accel+decel same
//     cycle -> speed unchanged; reset mid-PWM-high -> dc_pwm 0 next edge.

Source files
------------

// File: rtl/rc_car_top.sv
// rtl/rc_car_top.sv - RC-car control: debounced buttons, DC/servo PWM, 7-seg scan, status LEDs

// Two-flop synchronizer plus stability counter; emits a one-cycle pulse on an accepted rising edge
module rc_car_debounce #(
  parameter int CYCLES = 50_000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic btn_i,
  output logic rise_o
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  // Count consecutive samples that disagree with the accepted level; flip after CYCLES of them
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        rise_q   <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = rise_q;
endmodule

module rc_car_top #(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int DC_PERIOD       = 5_000,
  parameter int SERVO_PERIOD    = 2_000_000,
  parameter int SERVO_CENTER    = 150_000,
  parameter int SERVO_STEP      = 12_500,
  parameter int SCAN_CYCLES     = 100_000
) (
  input  logic       clk_100mhz,
  input  logic       rst_btn,
  input  logic       btn_accel,
  input  logic       btn_decel,
  input  logic       btn_servo_left,
  input  logic       btn_servo_right,
  input  logic [2:0] gear_sw,
  output logic       dc_pwm,
  output logic       servo_pwm,
  output logic [3:0] fnd_sel,
  output logic [7:0] fnd_seg,
  output logic [7:0] leds
);
  localparam int DCW     = $clog2(DC_PERIOD + 1);
  localparam int SVW     = $clog2(SERVO_PERIOD + 1);
  localparam int SCW     = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DC_UNIT = DC_PERIOD / 100;

  logic accel_p, decel_p, left_p, right_p;

  rc_car_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_accel (
    .clk_i(clk_100mhz), .rstn_i(rst_btn), .btn_i(btn_accel), .rise_o(accel_p));
  rc_car_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_decel (
    .clk_i(clk_100mhz), .rstn_i(rst_btn), .btn_i(btn_decel), .rise_o(decel_p));
  rc_car_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk_i(clk_100mhz), .rstn_i(rst_btn), .btn_i(btn_servo_left), .rise_o(left_p));
  rc_car_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk_i(clk_100mhz), .rstn_i(rst_btn), .btn_i(btn_servo_right), .rise_o(right_p));

  logic [3:0]        speed_q;
  logic signed [3:0] pos_q;
  logic [2:0]        gear_s1_q;
  logic [2:0]        gear_q;

  // Speed and steering state; opposing pulses in the same cycle cancel out
  always_ff @(posedge clk_100mhz) begin
    if (!rst_btn) begin
      speed_q   <= '0;
      pos_q     <= '0;
      gear_s1_q <= '0;
      gear_q    <= '0;
    end else begin
      gear_s1_q <= gear_sw;
      gear_q    <= gear_s1_q;
      if (accel_p && !decel_p && speed_q != 4'd10) begin
        speed_q <= speed_q + 4'd1;
      end else if (decel_p && !accel_p && speed_q != 4'd0) begin
        speed_q <= speed_q - 4'd1;
      end
      if (right_p && !left_p && pos_q != 4'sd4) begin
        pos_q <= pos_q + 4'sd1;
      end else if (left_p && !right_p && pos_q != -4'sd4) begin
        pos_q <= pos_q - 4'sd1;
      end
    end
  end

  logic [2:0]     gear_eff;
  logic [6:0]     speed_pct;
  logic [6:0]     gear_pct;
  logic [6:0]     duty_pct;
  logic [DCW-1:0] dc_thr_new;
  int             servo_w_int;
  logic [SVW-1:0] servo_w_new;

  // Duty is the lower of the speed request and the gear cap; gears above 5 behave as 5
  always_comb begin
    gear_eff    = (gear_q > 3'd5) ? 3'd5 : gear_q;
    speed_pct   = 7'(speed_q) * 7'd10;
    gear_pct    = 7'(gear_eff) * 7'd20;
    duty_pct    = (speed_pct < gear_pct) ? speed_pct : gear_pct;
    dc_thr_new  = DCW'(32'(duty_pct) * 32'(DC_UNIT));
    servo_w_int = SERVO_CENTER + int'(pos_q) * SERVO_STEP;
    servo_w_new = SVW'(servo_w_int);
  end

  logic [DCW-1:0] dc_cnt_q;
  logic [DCW-1:0] dc_thr_q;
  logic [DCW-1:0] dc_thr_cur;
  logic           dc_pwm_q;

  assign dc_thr_cur = (dc_cnt_q == '0) ? dc_thr_new : dc_thr_q;

  // DC PWM; threshold only reloads at period start so a period is never cut short
  always_ff @(posedge clk_100mhz) begin
    if (!rst_btn) begin
      dc_cnt_q <= '0;
      dc_thr_q <= '0;
      dc_pwm_q <= 1'b0;
    end else begin
      dc_cnt_q <= (dc_cnt_q == DCW'(DC_PERIOD - 1)) ? '0 : dc_cnt_q + 1'b1;
      if (dc_cnt_q == '0) dc_thr_q <= dc_thr_new;
      dc_pwm_q <= (dc_cnt_q < dc_thr_cur);
    end
  end

  logic [SVW-1:0] sv_cnt_q;
  logic [SVW-1:0] sv_w_q;
  logic [SVW-1:0] sv_w_cur;
  logic           servo_pwm_q;

  assign sv_w_cur = (sv_cnt_q == '0) ? servo_w_new : sv_w_q;

  // Servo frame; pulse width reloads at frame start
  always_ff @(posedge clk_100mhz) begin
    if (!rst_btn) begin
      sv_cnt_q    <= '0;
      sv_w_q      <= '0;
      servo_pwm_q <= 1'b0;
    end else begin
      sv_cnt_q <= (sv_cnt_q == SVW'(SERVO_PERIOD - 1)) ? '0 : sv_cnt_q + 1'b1;
      if (sv_cnt_q == '0) sv_w_q <= servo_w_new;
      servo_pwm_q <= (sv_cnt_q < sv_w_cur);
    end
  end

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  logic [SCW-1:0] scan_cnt_q;
  logic [1:0]     dig_q;
  logic [3:0]     sel_d;
  logic [7:0]     seg_d;
  logic [3:0]     fnd_sel_q;
  logic [7:0]     fnd_seg_q;
  logic [7:0]     leds_q;
  logic [3:0]     tens;
  logic [3:0]     units;

  // Pattern for the digit currently being scanned; leading zeros blanked
  always_comb begin
    tens  = 4'((duty_pct / 7'd10) % 7'd10);
    units = 4'(duty_pct % 7'd10);
    sel_d = ~(4'b0001 << dig_q);
    case (dig_q)
      2'd3:    seg_d = seg_code({1'b0, gear_eff}) & 8'h7F;
      2'd2:    seg_d = (duty_pct == 7'd100) ? 8'hF9 : 8'hFF;
      2'd1:    seg_d = (duty_pct < 7'd10) ? 8'hFF : seg_code(tens);
      default: seg_d = seg_code(units);
    endcase
  end

  // Digit scan timing and registered pin drivers for display and LEDs
  always_ff @(posedge clk_100mhz) begin
    if (!rst_btn) begin
      scan_cnt_q <= '0;
      dig_q      <= '0;
      fnd_sel_q  <= 4'b1110;
      fnd_seg_q  <= 8'hC0;
      leds_q     <= '0;
    end else begin
      if (scan_cnt_q == SCW'(SCAN_CYCLES - 1)) begin
        scan_cnt_q <= '0;
        dig_q      <= dig_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      fnd_sel_q <= sel_d;
      fnd_seg_q <= seg_d;
      leds_q    <= {speed_q, pos_q};
    end
  end

  assign dc_pwm    = dc_pwm_q;
  assign servo_pwm = servo_pwm_q;
  assign fnd_sel   = fnd_sel_q;
  assign fnd_seg   = fnd_seg_q;
  assign leds      = leds_q;
endmodule

// File: tb/tb_rc_car_top.sv
// tb/tb_rc_car_top.sv - self-checking bench for rc_car_top with scaled-down timing
module tb_rc_car_top;
  localparam int DB  = 16;
  localparam int DCP = 200;
  localparam int SVP = 1000;
  localparam int SVC = 120;
  localparam int SVS = 10;
  localparam int SCN = 16;

  logic       clk = 1'b0;
  logic       rst_btn = 1'b0;
  logic       btn_accel = 1'b0, btn_decel = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [2:0] gear_sw = 3'd0;
  logic       dc_pwm, servo_pwm;
  logic [3:0] fnd_sel;
  logic [7:0] fnd_seg, leds;

  rc_car_top #(
    .DEBOUNCE_CYCLES(DB), .DC_PERIOD(DCP), .SERVO_PERIOD(SVP),
    .SERVO_CENTER(SVC), .SERVO_STEP(SVS), .SCAN_CYCLES(SCN)
  ) dut (
    .clk_100mhz(clk), .rst_btn(rst_btn),
    .btn_accel(btn_accel), .btn_decel(btn_decel),
    .btn_servo_left(btn_left), .btn_servo_right(btn_right),
    .gear_sw(gear_sw), .dc_pwm(dc_pwm), .servo_pwm(servo_pwm),
    .fnd_sel(fnd_sel), .fnd_seg(fnd_seg), .leds(leds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_speed = 0;
  int m_pos = 0;
  bit check_en = 1'b0;
  logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // edges since reset was last released
  always @(posedge clk) cyc <= rst_btn ? cyc + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int duty_of(input int spd, input int gear);
    int g, a, b;
    g = (gear > 5) ? 5 : gear;
    a = spd * 10;
    b = g * 20;
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] exp_seg(input int digit, input int duty, input int gear);
    int g;
    logic [7:0] c;
    g = (gear > 5) ? 5 : gear;
    case (digit)
      3: begin c = codes[g]; c[7] = 1'b0; end
      2: c = (duty == 100) ? codes[1] : 8'hFF;
      1: c = (duty < 10) ? 8'hFF : codes[(duty / 10) % 10];
      default: c = codes[duty % 10];
    endcase
    return c;
  endfunction

  // Every settled cycle: outputs follow from the model state and cycles since reset
  always @(negedge clk) begin
    if (check_en) begin
      int n, duty, thr, w, d;
      logic [3:0] one4, s4, p4;
      n    = cyc;
      duty = duty_of(m_speed, int'(gear_sw));
      thr  = duty * (DCP / 100);
      w    = SVC + m_pos * SVS;
      d    = ((n - 1) / SCN) % 4;
      one4 = 4'b0001;
      s4   = m_speed[3:0];
      p4   = m_pos[3:0];
      chk("cyc dc_pwm", {31'd0, dc_pwm}, {31'd0, (((n - 1) % DCP) < thr)});
      chk("cyc servo_pwm", {31'd0, servo_pwm}, {31'd0, (((n - 1) % SVP) < w)});
      chk("cyc leds", {24'd0, leds}, {24'd0, s4, p4});
      chk("cyc fnd_sel", {28'd0, fnd_sel}, {28'd0, ~(one4 << d)});
      chk("cyc fnd_seg", {24'd0, fnd_seg}, {24'd0, exp_seg(d, duty, int'(gear_sw))});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 accel, 1 decel, 2 left, 3 right, 4 accel+decel, 5 left+right
  task automatic press(input int which, input int hold);
    case (which)
      0: btn_accel = 1'b1;
      1: btn_decel = 1'b1;
      2: btn_left  = 1'b1;
      3: btn_right = 1'b1;
      4: begin btn_accel = 1'b1; btn_decel = 1'b1; end
      default: begin btn_left = 1'b1; btn_right = 1'b1; end
    endcase
    tick(hold);
    btn_accel = 1'b0; btn_decel = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    tick(40);
    if (hold >= DB + 4) begin
      case (which)
        0: if (m_speed < 10) m_speed++;
        1: if (m_speed > 0) m_speed--;
        2: if (m_pos > -4) m_pos--;
        3: if (m_pos < 4) m_pos++;
        default: ;
      endcase
    end
  endtask

  int dc_hi, sv_hi;
  logic [7:0] dseg [4];

  // settle, then one servo frame of per-cycle checks while measuring pulse totals
  task automatic window();
    check_en = 1'b0;
    tick(SVP + 10);
    dc_hi = 0; sv_hi = 0;
    for (int i = 0; i < 4; i++) dseg[i] = 8'h00;
    check_en = 1'b1;
    for (int i = 0; i < SVP; i++) begin
      @(negedge clk);
      dc_hi += int'(dc_pwm);
      sv_hi += int'(servo_pwm);
      case (fnd_sel)
        4'b1110: dseg[0] = fnd_seg;
        4'b1101: dseg[1] = fnd_seg;
        4'b1011: dseg[2] = fnd_seg;
        4'b0111: dseg[3] = fnd_seg;
        default: ;
      endcase
    end
    check_en = 1'b0;
  endtask

  task automatic lit(input string tag, input int e_dc, input int e_sv, input logic [7:0] e_led,
                     input logic [7:0] d3, input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    chk({tag, " dc_high"}, dc_hi, e_dc);
    chk({tag, " servo_high"}, sv_hi, e_sv);
    chk({tag, " leds"}, {24'd0, leds}, {24'd0, e_led});
    chk({tag, " dig3"}, {24'd0, dseg[3]}, {24'd0, d3});
    chk({tag, " dig2"}, {24'd0, dseg[2]}, {24'd0, d2});
    chk({tag, " dig1"}, {24'd0, dseg[1]}, {24'd0, d1});
    chk({tag, " dig0"}, {24'd0, dseg[0]}, {24'd0, d0});
  endtask

  initial begin
    tick(3);
    chk("reset dc_pwm", {31'd0, dc_pwm}, 32'd0);
    chk("reset servo_pwm", {31'd0, servo_pwm}, 32'd0);
    chk("reset fnd_sel", {28'd0, fnd_sel}, 32'he);
    chk("reset fnd_seg", {24'd0, fnd_seg}, 32'hc0);
    chk("reset leds", {24'd0, leds}, 32'h0);
    rst_btn = 1'b1;

    // neutral gear, idle
    window();
    lit("idle", 0, 120, 8'h00, 8'h40, 8'hFF, 8'hFF, 8'hC0);

    // gear 1, five accel presses
    gear_sw = 3'd1;
    for (int i = 0; i < 5; i++) press(0, 40);
    window();
    lit("g1s5", 5 * 40, 120, 8'h50, 8'h79, 8'hFF, 8'hA4, 8'hC0);

    // gear 3
    gear_sw = 3'd3;
    window();
    lit("g3s5", 5 * 100, 120, 8'h50, 8'h30, 8'hFF, 8'h92, 8'hC0);

    // three decels, a short glitch, and simultaneous accel+decel
    for (int i = 0; i < 3; i++) press(1, 40);
    press(0, 5);
    press(4, 40);
    window();
    lit("g3s2", 5 * 40, 120, 8'h20, 8'h30, 8'hFF, 8'hA4, 8'hC0);

    // saturate speed, gear 7 behaves as 5
    for (int i = 0; i < 12; i++) press(0, 40);
    gear_sw = 3'd7;
    window();
    lit("g7s10", 1000, 120, 8'hA0, 8'h12, 8'hF9, 8'hC0, 8'hC0);

    // steering
    press(3, 40); press(3, 40);
    press(5, 40);
    window();
    lit("pos+2", 1000, 140, 8'hA2, 8'h12, 8'hF9, 8'hC0, 8'hC0);
    press(2, 40); press(2, 40);
    window();
    lit("pos0", 1000, 120, 8'hA0, 8'h12, 8'hF9, 8'hC0, 8'hC0);
    for (int i = 0; i < 6; i++) press(2, 40);
    window();
    lit("pos-4", 1000, 80, 8'hAC, 8'h12, 8'hF9, 8'hC0, 8'hC0);

    // reset while dc_pwm is high
    chk("pre-reset dc_pwm", {31'd0, dc_pwm}, 32'd1);
    rst_btn = 1'b0;
    tick(1);
    m_speed = 0; m_pos = 0;
    chk("midrst dc_pwm", {31'd0, dc_pwm}, 32'd0);
    chk("midrst servo_pwm", {31'd0, servo_pwm}, 32'd0);
    chk("midrst fnd_sel", {28'd0, fnd_sel}, 32'he);
    chk("midrst fnd_seg", {24'd0, fnd_seg}, 32'hc0);
    chk("midrst leds", {24'd0, leds}, 32'h0);
    tick(2);
    rst_btn = 1'b1;
    window();
    lit("postrst", 0, 120, 8'h00, 8'h12, 8'hFF, 8'hFF, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
